// File: rtl/typed_pipe_slice.sv
// typed_pipe_slice: valid/ready slice for any packed payload.
// MODE 0 passthrough, 1 forward register, 2 two-entry skid buffer.
module typed_pipe_slice #(
  parameter type TYPE_T = logic [255:0],
  parameter int  MODE   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  TYPE_T      fwd_data,
  input  logic       fwd_valid,
  output logic       fwd_ready,
  output TYPE_T      rev_data,
  output logic       rev_valid,
  input  logic       rev_ready,
  output logic [1:0] occupancy
);

  if (MODE == 0) begin : g_pass
    logic w_unused;

    assign rev_data  = fwd_data;
    assign rev_valid = fwd_valid;
    assign fwd_ready = rev_ready;
    assign occupancy = 2'd0;
    assign w_unused  = ^{clk, rst_n, flush};

  end else if (MODE == 1) begin : g_fwd
    TYPE_T r_data;
    logic  r_valid;
    logic  w_push;
    logic  w_pop;

    // rst_n gates ready so nothing is accepted while held in reset
    assign fwd_ready = (~r_valid | rev_ready) & ~flush & rst_n;
    assign w_push    = fwd_valid & fwd_ready;
    assign w_pop     = r_valid & rev_ready;
    assign rev_data  = r_data;
    assign rev_valid = r_valid;
    assign occupancy = {1'b0, r_valid};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (flush) begin
        r_valid <= 1'b0;
      end else if (w_push) begin
        r_valid <= 1'b1;
        r_data  <= fwd_data;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end

    a_hold1: assert property (@(posedge clk) disable iff (!rst_n)
      (r_valid && !rev_ready && !flush) |=> (r_valid && $stable(r_data)));

  end else if (MODE == 2) begin : g_skid
    typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
    } state_e;

    state_e r_state;
    TYPE_T  r_main;
    TYPE_T  r_skid;
    logic   r_ready_q;
    logic   w_push;
    logic   w_pop;

    assign fwd_ready = r_ready_q & ~flush;
    assign w_push    = fwd_valid & fwd_ready;
    assign w_pop     = rev_valid & rev_ready;
    assign rev_data  = r_main;
    assign rev_valid = (r_state != S_EMPTY);

    always_comb begin
      occupancy = 2'd0;
      case (r_state)
        S_EMPTY: occupancy = 2'd0;
        S_ONE:   occupancy = 2'd1;
        S_FULL:  occupancy = 2'd2;
        default: occupancy = 2'd0;
      endcase
    end

    // r_ready_q tracks "next state is not FULL"
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state   <= S_EMPTY;
        r_main    <= '0;
        r_skid    <= '0;
        r_ready_q <= 1'b0;
      end else if (flush) begin
        r_state   <= S_EMPTY;
        r_ready_q <= 1'b1;
      end else begin
        r_ready_q <= 1'b1;
        case (r_state)
          S_EMPTY: begin
            if (w_push) begin
              r_state <= S_ONE;
              r_main  <= fwd_data;
            end
          end
          S_ONE: begin
            if (w_push && w_pop) begin
              r_main <= fwd_data;
            end else if (w_push) begin
              r_state   <= S_FULL;
              r_skid    <= fwd_data;
              r_ready_q <= 1'b0;
            end else if (w_pop) begin
              r_state <= S_EMPTY;
            end
          end
          S_FULL: begin
            if (w_pop) begin
              r_state <= S_ONE;
              r_main  <= r_skid;
            end else begin
              r_ready_q <= 1'b0;
            end
          end
          default: r_state <= S_EMPTY;
        endcase
      end
    end

    a_hold2: assert property (@(posedge clk) disable iff (!rst_n)
      (rev_valid && !rev_ready && !flush) |=> (rev_valid && $stable(r_main)));
    a_full2: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state == S_FULL) |-> !fwd_ready);

  end else begin : g_bad
    logic w_unused;

    $error("typed_pipe_slice: MODE must be 0, 1 or 2");
    assign rev_data  = '0;
    assign rev_valid = 1'b0;
    assign fwd_ready = 1'b0;
    assign occupancy = 2'd0;
    assign w_unused  = ^{clk, rst_n, flush, fwd_data, fwd_valid, rev_ready};
  end

endmodule

// File: tb/tb_typed_pipe_slice.sv
// tb_typed_pipe_slice: directed and randomized checks of all three modes.
// A queue per slice models in-order delivery and capacity.
module tb_typed_pipe_slice;
  typedef logic [31:0] data_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_t fd0, rd0, fd1, rd1, fd2, rd2;
  logic fv0, fr0, rv0, rr0, fl0;
  logic fv1, fr1, rv1, rr1, fl1;
  logic fv2, fr2, rv2, rr2, fl2;
  logic [1:0] oc0, oc1, oc2;

  int checks = 0;
  int failures = 0;

  typed_pipe_slice #(.TYPE_T(data_t), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(fl0),
    .fwd_data(fd0), .fwd_valid(fv0), .fwd_ready(fr0),
    .rev_data(rd0), .rev_valid(rv0), .rev_ready(rr0),
    .occupancy(oc0));

  typed_pipe_slice #(.TYPE_T(data_t), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(fl1),
    .fwd_data(fd1), .fwd_valid(fv1), .fwd_ready(fr1),
    .rev_data(rd1), .rev_valid(rv1), .rev_ready(rr1),
    .occupancy(oc1));

  typed_pipe_slice #(.TYPE_T(data_t), .MODE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(fl2),
    .fwd_data(fd2), .fwd_valid(fv2), .fwd_ready(fr2),
    .rev_data(rd2), .rev_valid(rv2), .rev_ready(rr2),
    .occupancy(oc2));

  task automatic idle_all();
    fd0 = '0; fv0 = 0; rr0 = 0; fl0 = 0;
    fd1 = '0; fv1 = 0; rr1 = 0; fl1 = 0;
    fd2 = '0; fv2 = 0; rr2 = 0; fl2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    #12;
    checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL rst_rv1 got=%0h exp=0", rv1); end
    checks++; if (oc1 !== 2'd0) begin failures++; $display("FAIL rst_oc1 got=%0d exp=0", oc1); end
    checks++; if (fr1 !== 1'b0) begin failures++; $display("FAIL rst_fr1 got=%0h exp=0", fr1); end
    checks++; if (rd1 !== 32'h0) begin failures++; $display("FAIL rst_rd1 got=%0h exp=0", rd1); end
    checks++; if (rv2 !== 1'b0) begin failures++; $display("FAIL rst_rv2 got=%0h exp=0", rv2); end
    checks++; if (oc2 !== 2'd0) begin failures++; $display("FAIL rst_oc2 got=%0d exp=0", oc2); end
    checks++; if (fr2 !== 1'b0) begin failures++; $display("FAIL rst_fr2 got=%0h exp=0", fr2); end
    checks++; if (rd2 !== 32'h0) begin failures++; $display("FAIL rst_rd2 got=%0h exp=0", rd2); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (fr2 !== 1'b0) begin failures++; $display("FAIL rel_fr2_pre got=%0h exp=0", fr2); end
    checks++; if (fr1 !== 1'b1) begin failures++; $display("FAIL rel_fr1 got=%0h exp=1", fr1); end
    @(posedge clk);
    #1;
    checks++; if (fr2 !== 1'b1) begin failures++; $display("FAIL rel_fr2_post got=%0h exp=1", fr2); end
  endtask

  task automatic test_mode0();
    @(negedge clk);
    fd0 = 32'hA5; fv0 = 1; rr0 = 0;
    #1;
    checks++; if (rd0 !== 32'hA5) begin failures++; $display("FAIL m0_rd got=%0h exp=a5", rd0); end
    checks++; if (rv0 !== 1'b1) begin failures++; $display("FAIL m0_rv got=%0h exp=1", rv0); end
    checks++; if (fr0 !== 1'b0) begin failures++; $display("FAIL m0_fr got=%0h exp=0", fr0); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fd0 = $urandom; fv0 = 1'($urandom); rr0 = 1'($urandom); fl0 = 1'($urandom);
      #1;
      checks++; if (rd0 !== fd0) begin failures++; $display("FAIL m0_rnd_rd got=%0h exp=%0h", rd0, fd0); end
      checks++; if (rv0 !== fv0) begin failures++; $display("FAIL m0_rnd_rv got=%0h exp=%0h", rv0, fv0); end
      checks++; if (fr0 !== rr0) begin failures++; $display("FAIL m0_rnd_fr got=%0h exp=%0h", fr0, rr0); end
      checks++; if (oc0 !== 2'd0) begin failures++; $display("FAIL m0_rnd_oc got=%0d exp=0", oc0); end
    end
    fv0 = 0; rr0 = 0; fl0 = 0;
  endtask

  task automatic test_mode1_stream();
    rr1 = 1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (rv1 !== 1'b1) begin failures++; $display("FAIL m1_rv beat=%0d got=%0h exp=1", i-1, rv1); end
        checks++; if (rd1 !== data_t'(i-1)) begin failures++; $display("FAIL m1_rd got=%0h exp=%0h", rd1, i-1); end
        checks++; if (oc1 !== 2'd1) begin failures++; $display("FAIL m1_oc got=%0d exp=1", oc1); end
      end
      fd1 = data_t'(i);
      fv1 = (i < 8);
      #1;
      if (i < 8) begin
        checks++; if (fr1 !== 1'b1) begin failures++; $display("FAIL m1_fr beat=%0d got=%0h exp=1", i, fr1); end
      end
    end
    @(negedge clk);
    checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL m1_drain got=%0h exp=0", rv1); end
    rr1 = 0;
  endtask

  task automatic fill2(input data_t a, input data_t b);
    @(negedge clk);
    fd2 = a; fv2 = 1; rr2 = 0;
    @(negedge clk);
    fd2 = b;
    @(negedge clk);
    fv2 = 0;
    #1;
  endtask

  task automatic test_mode2_backpressure();
    fill2(32'd1, 32'd2);
    checks++; if (oc2 !== 2'd2) begin failures++; $display("FAIL m2_bp_oc got=%0d exp=2", oc2); end
    checks++; if (fr2 !== 1'b0) begin failures++; $display("FAIL m2_bp_fr got=%0h exp=0", fr2); end
    checks++; if (rd2 !== 32'd1) begin failures++; $display("FAIL m2_bp_head got=%0h exp=1", rd2); end
    rr2 = 1;
    @(negedge clk);
    checks++; if (rd2 !== 32'd2) begin failures++; $display("FAIL m2_bp_second got=%0h exp=2", rd2); end
    checks++; if (fr2 !== 1'b1) begin failures++; $display("FAIL m2_bp_fr_back got=%0h exp=1", fr2); end
    checks++; if (oc2 !== 2'd1) begin failures++; $display("FAIL m2_bp_oc1 got=%0d exp=1", oc2); end
    @(negedge clk);
    checks++; if (rv2 !== 1'b0) begin failures++; $display("FAIL m2_bp_empty got=%0h exp=0", rv2); end
    rr2 = 0;
  endtask

  task automatic test_mode2_reset();
    fill2(32'hC1, 32'hC2);
    checks++; if (oc2 !== 2'd2) begin failures++; $display("FAIL m2r_full got=%0d exp=2", oc2); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rv2 !== 1'b0) begin failures++; $display("FAIL m2r_rv got=%0h exp=0", rv2); end
    checks++; if (oc2 !== 2'd0) begin failures++; $display("FAIL m2r_oc got=%0d exp=0", oc2); end
    checks++; if (fr2 !== 1'b0) begin failures++; $display("FAIL m2r_fr got=%0h exp=0", fr2); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (fr2 !== 1'b0) begin failures++; $display("FAIL m2r_fr_pre got=%0h exp=0", fr2); end
    @(posedge clk);
    #1;
    checks++; if (fr2 !== 1'b1) begin failures++; $display("FAIL m2r_fr_post got=%0h exp=1", fr2); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    fd1 = 32'h55; fv1 = 1; rr1 = 0;
    fd2 = 32'h11; fv2 = 1; rr2 = 0;
    @(negedge clk);
    fv1 = 0;
    fd2 = 32'h22;
    @(negedge clk);
    fv2 = 0;
    #1;
    checks++; if (oc2 !== 2'd2) begin failures++; $display("FAIL fl_pre_oc2 got=%0d exp=2", oc2); end
    @(negedge clk);
    fl1 = 1; fv1 = 1; fd1 = 32'h66;
    fl2 = 1; fv2 = 1; fd2 = 32'h33; rr2 = 1;
    #1;
    checks++; if (fr2 !== 1'b0) begin failures++; $display("FAIL fl_fr2 got=%0h exp=0", fr2); end
    checks++; if (rv2 !== 1'b1) begin failures++; $display("FAIL fl_rv2 got=%0h exp=1", rv2); end
    checks++; if (rd2 !== 32'h11) begin failures++; $display("FAIL fl_head2 got=%0h exp=11", rd2); end
    checks++; if (fr1 !== 1'b0) begin failures++; $display("FAIL fl_fr1 got=%0h exp=0", fr1); end
    checks++; if (rd1 !== 32'h55) begin failures++; $display("FAIL fl_rd1 got=%0h exp=55", rd1); end
    @(negedge clk);
    fl1 = 0; fv1 = 0; fl2 = 0; fv2 = 0;
    #1;
    checks++; if (rv2 !== 1'b0) begin failures++; $display("FAIL fl_post_rv2 got=%0h exp=0", rv2); end
    checks++; if (oc2 !== 2'd0) begin failures++; $display("FAIL fl_post_oc2 got=%0d exp=0", oc2); end
    checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL fl_post_rv1 got=%0h exp=0", rv1); end
    checks++; if (oc1 !== 2'd0) begin failures++; $display("FAIL fl_post_oc1 got=%0d exp=0", oc1); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rv2 !== 1'b0) begin failures++; $display("FAIL fl_ghost got=%0h data=%0h exp=0", rv2, rd2); end
    end
    rr2 = 0;
  endtask

  task automatic test_random();
    data_t q1[$];
    data_t q2[$];
    int pops1 = 0;
    int pops2 = 0;
    int cyc = 0;
    logic exp_fr;
    do_reset();
    while ((pops1 < 10000 || pops2 < 10000) && cyc < 40000) begin
      @(negedge clk);
      fd1 = $urandom; fv1 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0); fl1 = ($urandom_range(0, 63) == 0);
      fd2 = $urandom; fv2 = ($urandom_range(0, 3) != 0);
      rr2 = ($urandom_range(0, 3) != 0); fl2 = ($urandom_range(0, 63) == 0);
      #1;
      exp_fr = (q1.size() == 0 || rr1) && !fl1;
      checks++; if (rv1 !== (q1.size() > 0)) begin failures++; $display("FAIL rnd1_rv cyc=%0d got=%0h exp=%0h", cyc, rv1, q1.size() > 0); end
      checks++; if (oc1 !== 2'(q1.size())) begin failures++; $display("FAIL rnd1_oc cyc=%0d got=%0d exp=%0d", cyc, oc1, q1.size()); end
      checks++; if (fr1 !== exp_fr) begin failures++; $display("FAIL rnd1_fr cyc=%0d got=%0h exp=%0h", cyc, fr1, exp_fr); end
      if (q1.size() > 0) begin
        checks++; if (rd1 !== q1[0]) begin failures++; $display("FAIL rnd1_rd cyc=%0d got=%0h exp=%0h", cyc, rd1, q1[0]); end
      end
      exp_fr = (q2.size() < 2) && !fl2;
      checks++; if (rv2 !== (q2.size() > 0)) begin failures++; $display("FAIL rnd2_rv cyc=%0d got=%0h exp=%0h", cyc, rv2, q2.size() > 0); end
      checks++; if (oc2 !== 2'(q2.size())) begin failures++; $display("FAIL rnd2_oc cyc=%0d got=%0d exp=%0d", cyc, oc2, q2.size()); end
      checks++; if (fr2 !== exp_fr) begin failures++; $display("FAIL rnd2_fr cyc=%0d got=%0h exp=%0h", cyc, fr2, exp_fr); end
      if (q2.size() > 0) begin
        checks++; if (rd2 !== q2[0]) begin failures++; $display("FAIL rnd2_rd cyc=%0d got=%0h exp=%0h", cyc, rd2, q2[0]); end
      end
      if (rv1 && rr1 && q1.size() > 0) begin void'(q1.pop_front()); pops1++; end
      if (fl1) q1.delete();
      else if (fv1 && fr1) q1.push_back(fd1);
      if (rv2 && rr2 && q2.size() > 0) begin void'(q2.pop_front()); pops2++; end
      if (fl2) q2.delete();
      else if (fv2 && fr2) q2.push_back(fd2);
      cyc++;
    end
    checks++;
    if (pops1 < 10000 || pops2 < 10000) begin
      failures++;
      $display("FAIL rnd_budget pops1=%0d pops2=%0d exp>=10000", pops1, pops2);
    end
    @(negedge clk);
    idle_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode0();
    test_mode1_stream();
    test_mode2_backpressure();
    test_mode2_reset();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
